// File: rtl/dmem_arb_pkg.sv
// Shared definitions for dmem_arbiter: func3 codes, FSM state type,
// port index type and load/store decode helpers. The data path is fixed
// at 32 bits, so the helpers operate on 32-bit words.
package dmem_arb_pkg;

   // RISC-V load/store func3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Requester index: 0 = core LSU, 1 = DMA/debug loader
   typedef logic port_t;

   // Access size in bytes; 0 marks an encoding that is never legal
   function automatic logic [2:0] f3_size(input logic [2:0] f3);
      case (f3)
         LB, LBU: f3_size = 3'd1;
         LH, LHU: f3_size = 3'd2;
         LW:      f3_size = 3'd4;
         default: f3_size = 3'd0;
      endcase
   endfunction

   // Stores only have the signed-less byte/half/word encodings
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) f3_legal = (f3 == SB) || (f3 == SH) || (f3 == SW);
      else    f3_legal = (f3_size(f3) != 3'd0);
   endfunction

   // Sign/zero extension of right-aligned memory read data
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         LB:      load_ext = {{24{d[7]}}, d[7:0]};
         LBU:     load_ext = {24'd0, d[7:0]};
         LH:      load_ext = {{16{d[15]}}, d[15:0]};
         LHU:     load_ext = {16'd0, d[15:0]};
         default: load_ext = d;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two request/response ports plus the single
// data-memory port. The slave modport is the arbiter's view, master is the
// view of the surroundings (requesters and memory together).
// Handshake: a request is accepted at a rising edge where
// req_valid[p] & req_ready[p]; a requester holds its fields stable while
// valid is high and ready is low. rsp_valid[p] is a one-cycle pulse that
// qualifies rsp_rdata and rsp_err.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import dmem_arb_pkg::*;

   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [1:0]             req_we;
   logic [1:0][ADDR_W-1:0] req_addr;
   logic [1:0][DATA_W-1:0] req_wdata;
   logic [1:0][2:0]        req_func3;

   logic [1:0]             rsp_valid;
   logic [DATA_W-1:0]      rsp_rdata;
   logic                   rsp_err;

   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [2:0]             mem_func3;
   logic                   mem_rd_en;
   logic                   mem_wr_en;
   logic [DATA_W-1:0]      mem_rdata;

   // Current arbiter FSM state, for observation only
   state_t                 dbg_state;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_func3, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_addr, mem_wdata, mem_func3, mem_rd_en, mem_wr_en, dbg_state
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_func3, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_addr, mem_wdata, mem_func3, mem_rd_en, mem_wr_en, dbg_state
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way arbiter with one-hot grant. Default build: round-robin with a
// last-grant pointer that moves only when i_advance (a handshake) is high.
// With DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins, no pointer.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
   wire w_unused = &{1'b0, clk, rst_n, i_advance};

   // Port 0 has absolute priority
   always_comb begin
      o_gnt = {i_req[1] & ~i_req[0], i_req[0]};
   end
`else
   // 1 = port 1 was granted last; reset value makes port 0 favoured
   logic r_last;

   // Pointer remembers the winner of the most recent handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_last <= 1'b1;
      else if (i_advance) r_last <= o_gnt[1];
   end

   // A lone requester always wins; on contention the other port wins
   always_comb begin
      o_gnt = i_req;
      if (&i_req) o_gnt = r_last ? 2'b01 : 2'b10;
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed data memory between the core
// LSU (port 0) and the DMA/debug loader (port 1). A winning request is
// checked for func3 legality, alignment and range; legal requests drive
// the memory for exactly one ACCESS cycle, illegal ones go straight to an
// error response. Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed
// priority (port 0 wins) instead of round-robin.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 2048
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("dmem_arbiter: DATA_W must be 32");
   end

   localparam logic [ADDR_W:0] LP_MEM_END = (ADDR_W+1)'(MEM_BYTES);

   state_t            r_state;
   logic              r_we;
   logic [2:0]        r_func3;
   port_t             r_port;

   logic [1:0]        w_gnt;
   logic [1:0]        w_ready;
   logic              w_hs;
   port_t             w_sel;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [2:0]        w_func3;
   logic [2:0]        w_size;
   logic [ADDR_W:0]   w_last;
   logic              w_misal;
   logic              w_ok;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (bus.req_valid),
      .i_advance (w_hs),
      .o_gnt     (w_gnt)
   );

   // Requests are accepted only while no memory access is in flight
   always_comb begin
      w_ready = (r_state != ACCESS) ? w_gnt : 2'b00;
      w_hs    = |w_ready;
   end

   assign bus.req_ready = w_ready;
   assign bus.dbg_state = r_state;

   // Select the winner and check it; range sum is one bit wider so it cannot wrap
   always_comb begin
      w_sel   = w_gnt[1];
      w_we    = bus.req_we[w_sel];
      w_addr  = bus.req_addr[w_sel];
      w_wdata = bus.req_wdata[w_sel];
      w_func3 = bus.req_func3[w_sel];
      w_size  = f3_size(w_func3);
      w_last  = {1'b0, w_addr} + {{(ADDR_W-2){1'b0}}, w_size} - {{ADDR_W{1'b0}}, 1'b1};
      w_misal = ((w_size == 3'd2) && w_addr[0]) ||
                ((w_size == 3'd4) && (w_addr[1:0] != 2'b00));
      w_ok    = f3_legal(w_we, w_func3) && !w_misal && (w_last < LP_MEM_END);
   end

   // Control FSM; memory and response outputs are registered so each
   // strobe is a clean single-cycle pulse that reset clears at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_we          <= 1'b0;
         r_func3       <= 3'd0;
         r_port        <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_func3 <= 3'd0;
         bus.mem_rd_en <= 1'b0;
         bus.mem_wr_en <= 1'b0;
         bus.rsp_valid <= 2'b00;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_func3 <= 3'd0;
         bus.mem_rd_en <= 1'b0;
         bus.mem_wr_en <= 1'b0;
         bus.rsp_valid <= 2'b00;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         case (r_state)
            ACCESS: begin
               r_state       <= RESP;
               bus.rsp_valid <= r_port ? 2'b10 : 2'b01;
               bus.rsp_rdata <= r_we ? '0 : load_ext(r_func3, bus.mem_rdata);
            end
            default: begin
               if (w_hs) begin
                  r_we    <= w_we;
                  r_func3 <= w_func3;
                  r_port  <= w_sel;
                  if (w_ok) begin
                     r_state       <= ACCESS;
                     bus.mem_addr  <= w_addr;
                     bus.mem_wdata <= w_wdata;
                     bus.mem_func3 <= w_func3;
                     bus.mem_rd_en <= ~w_we;
                     bus.mem_wr_en <= w_we;
                  end else begin
                     r_state       <= RESP;
                     bus.rsp_valid <= w_sel ? 2'b10 : 2'b01;
                     bus.rsp_err   <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
